// File: rtl/reg_wb_pkg.sv
// Shared defaults and drain-FSM encoding for the register writeback block.
//   WB_DEPTH / WB_DW / WB_AWW : default queue depth, data width, address width
//   drain_state_t             : drain FSM states (IDLE, WRITE, HOLD)
package reg_wb_pkg;

  localparam int unsigned WB_DEPTH = 4;
  localparam int unsigned WB_DW    = 32;
  localparam int unsigned WB_AWW   = 5;

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_WRITE = 2'd1,
    DRAIN_HOLD  = 2'd2
  } drain_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Result queue for reg_writeback: circular buffer with two push ports
// (push0 is older than push1 when both fire) and one pop port.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   push0/push0_dest/push0_data: first enqueue port
//   push1/push1_dest/push1_data: second enqueue port (lands after push0)
//   pop                        : drop the head entry
//   head_dest/head_data        : head entry contents
//   head_ptr                   : index of the oldest entry
//   count                      : number of valid entries
//   ent_valid/ent_dest/ent_data: per-entry state for forwarding lookup
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int unsigned  DEPTH = WB_DEPTH,
  parameter int unsigned  DW    = WB_DW,
  parameter int unsigned  AWW   = WB_AWW,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push0,
  input  logic [AWW-1:0]            push0_dest,
  input  logic [DW-1:0]             push0_data,
  input  logic                      push1,
  input  logic [AWW-1:0]            push1_dest,
  input  logic [DW-1:0]             push1_data,
  input  logic                      pop,
  output logic [AWW-1:0]            head_dest,
  output logic [DW-1:0]             head_data,
  output logic [PW-1:0]             head_ptr,
  output logic [CW-1:0]             count,
  output logic [DEPTH-1:0]          ent_valid,
  output logic [DEPTH-1:0][AWW-1:0] ent_dest,
  output logic [DEPTH-1:0][DW-1:0]  ent_data
);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] slot1;

  // push1 takes the slot after push0 only when push0 is also writing
  assign slot1 = push0 ? wr_ptr + PW'(1) : wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
      end
      if (push0) ent_valid[wr_ptr] <= 1'b1;
      if (push1) ent_valid[slot1]  <= 1'b1;
      wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
      count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push0) begin
      ent_dest[wr_ptr] <= push0_dest;
      ent_data[wr_ptr] <= push0_data;
    end
    if (push1) begin
      ent_dest[slot1] <= push1_dest;
      ent_data[slot1] <= push1_data;
    end
  end

  assign head_dest = ent_dest[rd_ptr];
  assign head_data = ent_data[rd_ptr];
  assign head_ptr  = rd_ptr;

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback stage. Accepts ALU and load results, queues them
// in acceptance order (load before ALU when both fire) and drains one per
// cycle into registered register-file write outputs. Also provides a
// combinational forwarding lookup over the queue and the output register.
// Ports:
//   clk, rst_n                         : clock, synchronous active-low reset
//   alu_valid/alu_dest/alu_data/alu_ready : ALU result channel
//   mem_valid/mem_dest/mem_data/mem_ready : load result channel
//   hold                               : suspend draining
//   RegWrite/AW/WriteData              : registered register-file write port
//   RA1/RA2, fwdN_hit/fwdN_data        : forwarding lookup
//   count, empty                       : queue occupancy, fully idle flag
module reg_writeback
  import reg_wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned DW    = WB_DW,
  parameter int unsigned AWW   = WB_AWW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [AWW-1:0]         alu_dest,
  input  logic [DW-1:0]          alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [AWW-1:0]         mem_dest,
  input  logic [DW-1:0]          mem_data,
  output logic                   mem_ready,
  input  logic                   hold,
  output logic                   RegWrite,
  output logic [AWW-1:0]         AW,
  output logic [DW-1:0]          WriteData,
  input  logic [AWW-1:0]         RA1,
  input  logic [AWW-1:0]         RA2,
  output logic                   fwd1_hit,
  output logic                   fwd2_hit,
  output logic [DW-1:0]          fwd1_data,
  output logic [DW-1:0]          fwd2_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  drain_state_t state, state_nxt;

  logic                      pop;
  logic                      mem_fire, alu_fire;
  logic                      push0, push1;
  logic [CW-1:0]             free;
  logic [AWW-1:0]            head_dest;
  logic [DW-1:0]             head_data;
  logic [PW-1:0]             head_ptr;
  logic [DEPTH-1:0]          ent_valid;
  logic [DEPTH-1:0][AWW-1:0] ent_dest;
  logic [DEPTH-1:0][DW-1:0]  ent_data;
  logic [PW-1:0]             idx;

  // Readiness looks only at the current occupancy; a pop this cycle does not
  // free a slot for this cycle's pushes.
  assign free      = CW'(DEPTH) - count;
  assign mem_ready = rst_n && (free != '0);
  assign alu_ready = rst_n && ((free >= CW'(2)) || ((free == CW'(1)) && !mem_valid));

  assign mem_fire = mem_valid && mem_ready;
  assign alu_fire = alu_valid && alu_ready;

  // Writes to r0 are accepted but dropped here.
  assign push0 = mem_fire && (mem_dest != '0);
  assign push1 = alu_fire && (alu_dest != '0);

  wb_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AWW   (AWW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push0      (push0),
    .push0_dest (mem_dest),
    .push0_data (mem_data),
    .push1      (push1),
    .push1_dest (alu_dest),
    .push1_data (alu_data),
    .pop        (pop),
    .head_dest  (head_dest),
    .head_data  (head_data),
    .head_ptr   (head_ptr),
    .count      (count),
    .ent_valid  (ent_valid),
    .ent_dest   (ent_dest),
    .ent_data   (ent_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= DRAIN_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DRAIN_IDLE: begin
        if (hold)               state_nxt = DRAIN_HOLD;
        else if (count != '0)   state_nxt = DRAIN_WRITE;
      end
      DRAIN_WRITE: begin
        if (hold)               state_nxt = DRAIN_HOLD;
        else if (count == '0)   state_nxt = DRAIN_IDLE;
      end
      DRAIN_HOLD: begin
        if (hold)               state_nxt = DRAIN_HOLD;
        else if (count != '0)   state_nxt = DRAIN_WRITE;
        else                    state_nxt = DRAIN_IDLE;
      end
      default:                  state_nxt = DRAIN_IDLE;
    endcase
  end

  // Entering WRITE is what moves the head into the output registers.
  assign pop = (state_nxt == DRAIN_WRITE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWrite  <= 1'b0;
      AW        <= '0;
      WriteData <= '0;
    end else if (pop) begin
      RegWrite  <= 1'b1;
      AW        <= head_dest;
      WriteData <= head_data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  assign empty = (count == '0) && !RegWrite;

  // Output register is older than anything queued; queue is scanned
  // oldest-to-youngest so the last match wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    idx       = '0;
    if (RegWrite && (AW == RA1)) begin
      fwd1_hit  = 1'b1;
      fwd1_data = WriteData;
    end
    if (RegWrite && (AW == RA2)) begin
      fwd2_hit  = 1'b1;
      fwd2_data = WriteData;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PW'(i);
      if (ent_valid[idx] && (ent_dest[idx] == RA1)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = ent_data[idx];
      end
      if (ent_valid[idx] && (ent_dest[idx] == RA2)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = ent_data[idx];
      end
    end
    if ((RA1 == '0) || !rst_n) begin
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
    end
    if ((RA2 == '0) || !rst_n) begin
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned AWW   = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           alu_valid, mem_valid, hold;
  logic [AWW-1:0] alu_dest, mem_dest, RA1, RA2;
  logic [DW-1:0]  alu_data, mem_data;
  logic           alu_ready, mem_ready, RegWrite, fwd1_hit, fwd2_hit, empty;
  logic [AWW-1:0] AW;
  logic [DW-1:0]  WriteData, fwd1_data, fwd2_data;
  logic [2:0]     count;

  typedef struct {
    logic [AWW-1:0] d;
    logic [DW-1:0]  v;
  } ent_t;

  ent_t           q[$];
  logic           m_rw = 1'b0;
  logic [AWW-1:0] m_aw = '0;
  logic [DW-1:0]  m_wd = '0;

  int total = 0;
  int bad   = 0;

  reg_writeback #(.DEPTH(DEPTH), .DW(DW), .AWW(AWW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .hold(hold), .RegWrite(RegWrite), .AW(AW), .WriteData(WriteData),
    .RA1(RA1), .RA2(RA2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Youngest queued match wins, then the result currently being written.
  function automatic void ref_fwd(input logic [AWW-1:0] ra, output bit hit,
                                  output logic [DW-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (ra == '0 || !rst_n) return;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].d == ra) begin
        hit  = 1'b1;
        data = q[i].v;
        return;
      end
    end
    if (m_rw && m_aw == ra) begin
      hit  = 1'b1;
      data = m_wd;
    end
  endfunction

  // One clock: compare everything at the falling edge, then advance the model
  // with the inputs that were presented across the rising edge.
  task automatic cyc();
    int unsigned   free;
    bit            mr, ar, h1, h2;
    logic [DW-1:0] d1, d2;
    ent_t          e;
    @(negedge clk);
    free = DEPTH - q.size();
    mr   = rst_n && (free >= 1);
    ar   = rst_n && ((free >= 2) || (free == 1 && !mem_valid));
    chk("mem_ready", mem_ready, mr);
    chk("alu_ready", alu_ready, ar);
    chk("count", count, q.size());
    chk("empty", empty, (q.size() == 0) && !m_rw);
    chk("regwrite", RegWrite, m_rw);
    if (m_rw) begin
      chk("aw", AW, m_aw);
      chk("writedata", WriteData, m_wd);
    end
    ref_fwd(RA1, h1, d1);
    ref_fwd(RA2, h2, d2);
    chk("fwd1_hit", fwd1_hit, h1);
    chk("fwd2_hit", fwd2_hit, h2);
    if (h1) chk("fwd1_data", fwd1_data, d1);
    if (h2) chk("fwd2_data", fwd2_data, d2);
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_rw = 1'b0;
      m_aw = '0;
      m_wd = '0;
    end else begin
      if (!hold && q.size() > 0) begin
        e    = q.pop_front();
        m_rw = 1'b1;
        m_aw = e.d;
        m_wd = e.v;
      end else begin
        m_rw = 1'b0;
      end
      if (mr && mem_valid && mem_dest != '0) q.push_back('{d: mem_dest, v: mem_data});
      if (ar && alu_valid && alu_dest != '0) q.push_back('{d: alu_dest, v: alu_data});
    end
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
    mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; RA1 = '0; RA2 = '0;
    idle_inputs();
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_regwrite", RegWrite, 0);

    // single ALU result
    alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'hDEADBEEF;
    cyc();
    idle_inputs();
    #1;
    chk("s1_count", count, 1);
    chk("s1_rw_n", RegWrite, 0);
    cyc();
    chk("s1_rw", RegWrite, 1);
    chk("s1_aw", AW, 3);
    chk("s1_wd", WriteData, 32'hDEADBEEF);
    cyc();
    chk("s1_empty", empty, 1);

    // simultaneous fire, mem ordered first
    mem_valid = 1'b1; mem_dest = 5'd7; mem_data = 32'h11;
    alu_valid = 1'b1; alu_dest = 5'd7; alu_data = 32'h22;
    RA1 = 5'd7;
    cyc();
    idle_inputs();
    #1;
    chk("s2_fwd_hit", fwd1_hit, 1);
    chk("s2_fwd", fwd1_data, 32'h22);
    cyc();
    chk("s2_wd1", WriteData, 32'h11);
    chk("s2_fwd_q", fwd1_data, 32'h22);
    cyc();
    chk("s2_wd2", WriteData, 32'h22);
    RA1 = '0;
    cyc();

    // full queue under hold
    hold = 1'b1;
    mem_valid = 1'b1; mem_dest = 5'd1; mem_data = 32'hA1;
    alu_valid = 1'b1; alu_dest = 5'd2; alu_data = 32'hA2;
    cyc();
    mem_dest = 5'd3; mem_data = 32'hA3;
    alu_dest = 5'd4; alu_data = 32'hA4;
    cyc();
    #1;
    chk("s3_count4", count, 4);
    chk("s3_mem_rdy0", mem_ready, 0);
    chk("s3_alu_rdy0", alu_ready, 0);
    cyc();
    hold = 1'b0;
    idle_inputs();
    cyc();
    chk("s3_count3", count, 3);
    hold = 1'b1;
    mem_valid = 1'b1; mem_dest = 5'd5; mem_data = 32'hA5;
    alu_valid = 1'b1; alu_dest = 5'd6; alu_data = 32'hA6;
    #1;
    chk("s3_mem_rdy1", mem_ready, 1);
    chk("s3_alu_rdy0b", alu_ready, 0);
    cyc();
    chk("s3_count4b", count, 4);
    hold = 1'b0;
    idle_inputs();
    repeat (6) cyc();

    // register zero is swallowed
    alu_valid = 1'b1; alu_dest = '0; alu_data = 32'h5; RA1 = '0;
    #1;
    chk("s4_alu_rdy", alu_ready, 1);
    cyc();
    idle_inputs();
    #1;
    chk("s4_count", count, 0);
    chk("s4_fwd", fwd1_hit, 0);
    cyc();
    chk("s4_rw", RegWrite, 0);

    // hold then reset discards the queue
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1; mem_dest = AWW'(i + 9); mem_data = 32'hC0 + i;
      cyc();
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("s5_hold_rw", RegWrite, 0);
      chk("s5_hold_cnt", count, 3);
    end
    hold = 1'b0; rst_n = 1'b0; RA1 = 5'd9;
    #1;
    chk("s5_rst_fwd", fwd1_hit, 0);
    chk("s5_rst_rdy", mem_ready, 0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("s5_nowrite", RegWrite, 0);
      chk("s5_cnt0", count, 0);
    end

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(99) != 0);
      hold      = ($urandom_range(4) == 0);
      mem_valid = $urandom_range(1);
      mem_dest  = AWW'($urandom_range(7));
      mem_data  = $urandom;
      alu_valid = $urandom_range(1);
      alu_dest  = AWW'($urandom_range(7));
      alu_data  = $urandom;
      RA1       = AWW'($urandom_range(7));
      RA2       = AWW'($urandom_range(7));
      cyc();
    end
    rst_n = 1'b1; hold = 1'b0;
    idle_inputs();
    repeat (6) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, meaning result-queue entries (power of two, >=2).
REQ-002 The block SHALL take parameter DW, default 32, meaning data width.
REQ-003 The block SHALL take parameter AWW, default 5, meaning register-address width.
REQ-004 The block SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port alu_valid  in  1  ALU result offered.
REQ-007 The block SHALL have ports alu_dest in AWW and alu_data in DW, giving the ALU result target and value.
REQ-008 The block SHALL have port alu_ready  out  1  ALU result accepted when alu_valid&&alu_ready.
REQ-009 The block SHALL have ports mem_valid in 1, mem_dest in AWW, mem_data in DW and mem_ready out 1, a load-result channel with identical semantics.
REQ-010 The block SHALL have port hold  in  1  suspend draining to the register file.
REQ-011 The block SHALL have ports RegWrite out 1, AW out AWW and WriteData out DW, the register-file write port, all registered.
REQ-012 The block SHALL have ports RA1 in AWW, RA2 in AWW, fwd1_hit out 1, fwd2_hit out 1, fwd1_data out DW and fwd2_data out DW, a combinational forwarding lookup.
REQ-013 The block SHALL have ports count out clog2(DEPTH)+1, giving queued entries, and empty out 1, meaning count==0 and RegWrite==0.

Function
REQ-014 Accepted results SHALL be queued FIFO and written to the register file in acceptance order, one per cycle.
REQ-015 When both channels fire in one cycle, mem SHALL be ordered before alu.
REQ-016 mem_ready SHALL be 1 when free slots >=1; alu_ready SHALL be 1 when free>=2, or when free==1 and mem_valid==0.
REQ-017 Ready SHALL be computed from the current count only; same-cycle dequeue SHALL NOT create space.
REQ-018 A result with dest==0 SHALL be accepted (ready rules unchanged) but SHALL NOT be queued, written or forwarded.
REQ-019 The drain FSM SHALL have the states IDLE (queue empty), WRITE (head popped into output regs, RegWrite=1) and HOLD (hold=1, RegWrite=0, queue kept).
REQ-020 The drain FSM transitions SHALL be: IDLE->WRITE when count>0 and !hold; WRITE->WRITE while count>0 and !hold; WRITE->IDLE when count==0; any->HOLD when hold; HOLD->WRITE/IDLE on hold release as above.
REQ-021 Latency SHALL be: result accepted at edge N gives RegWrite=1 with that AW/WriteData during cycle N+1 at earliest.
REQ-022 The count update SHALL handle simultaneous 0, 1 or 2 enqueues plus 0 or 1 dequeue in one cycle; wrap-around of the head/tail pointers SHALL be modulo DEPTH.
REQ-023 fwdN_hit SHALL be 1 when RAN!=0 matches an output-register entry with RegWrite=1, or a valid queue entry; fwdN_data SHALL come from the youngest match, with the queue taking precedence over the output register.
REQ-024 Results entering in the current cycle SHALL NOT be visible to forwarding.

Reset
REQ-025 When rst_n==0 at a clk edge, the block SHALL set: state IDLE, pointers 0, count 0, all entry valid bits 0, RegWrite 0, AW 0, WriteData 0.
REQ-026 Reset mid-operation SHALL discard all queued results without any write; during reset cycles, ready outputs SHALL be 0 and fwd hits SHALL be 0.

Structure
REQ-027 DW, AWW, DEPTH defaults and the drain state encoding SHALL reside in package reg_wb_pkg.
REQ-028 Queue storage and pointers SHALL be the sub-module wb_fifo (two push ports, one pop, per-entry dest/data/valid visible for lookup).

Verification
REQ-029 The bench SHALL cover single result: alu (dest 3, 0xDEADBEEF) at edge N -> RegWrite=1, AW=3, WriteData=0xDEADBEEF at N+1, then empty=1.
REQ-030 The bench SHALL cover simultaneous fire: mem (7, 0x11) and alu (7, 0x22) in one cycle -> writes 0x11 then 0x22; fwd on RA1=7 gives 0x22 while queued.
REQ-031 The bench SHALL cover full: hold=1 and 4 results -> count=4, both readys 0; with count=3 and both valid -> mem_ready=1, alu_ready=0.
REQ-032 The bench SHALL cover zero register: alu dest 0 with data 0x5 -> accepted, count unchanged, no RegWrite, RA1=0 gives fwd1_hit=0.
REQ-033 The bench SHALL cover hold/reset: 3 queued, hold for 5 cycles -> RegWrite 0, count 3; rst_n=0 for one edge -> count 0 and no writes afterward.
